// File: rtl/muldiv_unit_pkg.sv
// muldiv_defs: op and state encodings shared by the multiply/divide unit
package muldiv_defs;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_SIGN = 2'b10
  } md_state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-side request/response bundle of the multiply/divide unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa, opb, wdata, hi, lo, rdata;
  logic             mthi, mtlo, mfhi, mflo, busy, stall;
  modport master(output start, op, opa, opb, mthi, mtlo, wdata, mfhi, mflo,
                 input hi, lo, rdata, busy, stall);
  modport slave(input start, op, opa, opb, mthi, mtlo, wdata, mfhi, mflo,
                output hi, lo, rdata, busy, stall);
endinterface

// File: rtl/muldiv_unit_iter.sv
// muldiv_iter: one shift-add multiply or restoring divide step
module muldiv_iter #(parameter int WIDTH = 32) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0] w_sum, w_rem, w_try;
  always_comb begin
    w_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : '0);
    w_rem = {i_acc, i_q[WIDTH-1]};
    w_try = w_rem - {1'b0, i_b};
    o_acc = i_div ? (w_try[WIDTH] ? w_rem[WIDTH-1:0] : w_try[WIDTH-1:0]) : w_sum[WIDTH:1];
    o_q   = i_div ? {i_q[WIDTH-2:0], ~w_try[WIDTH]} : {w_sum[0], i_q[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mult/div FSM with architectural HI/LO and pipeline stall
module muldiv_unit import muldiv_defs::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_b, r_hi, r_lo, w_acc, w_q, w_aa, w_ab, w_hi, w_lo;
  logic             r_div, r_negq, r_negr, r_busy, w_div, w_sgn, w_sa, w_sb;
  logic [2*WIDTH-1:0] w_prod;
  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_div(r_div), .i_acc(r_acc), .i_q(r_q), .i_b(r_b), .o_acc(w_acc), .o_q(w_q)
  );
  // acc/q form the product {hi,lo} for multiply and {remainder,quotient} for divide
  always_comb begin
    w_div  = bus.op == MD_DIV || bus.op == MD_DIVU;
    w_sgn  = bus.op == MD_MULT || bus.op == MD_DIV;
    w_sa   = w_sgn & bus.opa[WIDTH-1];
    w_sb   = w_sgn & bus.opb[WIDTH-1];
    w_aa   = w_sa ? -bus.opa : bus.opa;
    w_ab   = w_sb ? -bus.opb : bus.opb;
    w_prod = r_negq ? -{r_acc, r_q} : {r_acc, r_q};
    w_hi   = r_div ? (r_negr ? -r_acc : r_acc) : w_prod[2*WIDTH-1:WIDTH];
    w_lo   = r_div ? (r_negq ? -r_q : r_q) : w_prod[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (bus.start) begin
            r_state <= MD_CALC;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_div   <= w_div;
            r_b     <= w_div ? w_ab : w_aa;
            r_q     <= w_div ? w_aa : w_ab;
            // zero divisor keeps the all-ones quotient; remainder fix restores raw opa
            r_negq  <= (w_sa ^ w_sb) & (|bus.opb);
            r_negr  <= w_sa;
          end else begin
            if (bus.mthi) r_hi <= bus.wdata;
            if (bus.mtlo) r_lo <= bus.wdata;
          end
        end
        MD_CALC: begin
          r_acc <= w_acc;
          r_q   <= w_q;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= MD_SIGN;
        end
        MD_SIGN: begin
          r_hi    <= w_hi;
          r_lo    <= w_lo;
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = r_busy;
  assign bus.rdata = bus.mfhi ? r_hi : r_lo;
  assign bus.stall = r_busy & (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo);
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with the architectural HI/LO registers for the MiniSys-1A pipeline. It executes `mult`, `multu`, `div` and `divu` issued from EX, serves `mfhi`, `mflo`, `mthi` and `mtlo`, and raises a pipeline stall while a HI/LO access or a new multiply/divide would collide with an operation in flight. It is sequenced by an internal FSM: one operand bit per cycle, then a sign-fix cycle.

## Interface
- `WIDTH`, 32: operand/HI/LO width.
- `CNT_W`, 5: iteration counter width; must equal log2(`WIDTH`).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: EX holds a mult/div this cycle.
- `op` in 2: 00 mult, 01 multu, 10 div, 11 divu.
- `opa` in WIDTH: rs value (multiplicand/dividend).
- `opb` in WIDTH: rt value (multiplier/divisor).
- `mthi` in 1: write `wdata` to HI.
- `mtlo` in 1: write `wdata` to LO.
- `wdata` in WIDTH: rs value for mthi/mtlo.
- `mfhi` in 1: read HI request.
- `mflo` in 1: read LO request.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `rdata` out WIDTH: `mfhi ? hi : lo`, combinational.
- `busy` out 1: operation in flight.
- `stall` out 1: `busy & (start | mfhi | mflo | mthi | mtlo)`, combinational.

## Operation
- **Reset:**
  - `hi` = `lo` = 0, `busy` = 0, state IDLE, counter 0.
  - A reset asserted mid-operation aborts it. No partial result is written.
- **States:** IDLE → CALC → SIGN → IDLE.
- **IDLE:**
  - `start` = 1 latches |opa|, |opb| (signed ops) or raw operands (unsigned ops), plus the result-sign flags and `op`.
  - Clears the accumulator, sets counter = 0, goes to CALC.
  - `start` has priority over `mthi`/`mtlo` in the same cycle; those writes are dropped.
  - Without `start`, `mthi`/`mtlo` write HI/LO at the edge. Both may assert together.
- **CALC:**
  - Runs one iteration per cycle, WIDTH iterations. Leaves to SIGN when counter = WIDTH-1.
  - Multiply: shift-add over a 2·WIDTH product register.
  - Divide: restoring divide; remainder register WIDTH+1 bits, quotient shifted in LSB-first.
- **SIGN:**
  - mult: negate the 64-bit product when sign(opa) ≠ sign(opb).
  - div: negate the quotient when the signs differ; the remainder takes sign(opa).
  - Writes HI = product[63:32] / remainder and LO = product[31:0] / quotient. Returns to IDLE.
- **Divide by zero** (`opb` = 0, div or divu): normal latency, HI = `opa` (raw), LO = 0xFFFF_FFFF. Sign fix is suppressed.
- **Overflow:** div 0x8000_0000 / 0xFFFF_FFFF gives LO = 0x8000_0000, HI = 0 (wraps, no trap). |0x8000_0000| is 0x8000_0000 unsigned.
- **Requests while busy:** `start`, `mthi`, `mtlo` while `busy` are ignored. The pipeline holds them via `stall` and re-presents them.

## Timing
- `start` sampled at edge E0. `busy` = 1 after E0. CALC spans E1..E32, SIGN at E33.
- After E33: `hi`/`lo` hold the result and `busy` = 0. Latency is 33 cycles; a new `start` is accepted at E33+1.
- `stall` is combinational from `busy` and the requests. `mfhi`/`mflo` return the final value in the first cycle that `stall` is 0.
- `hi`/`lo` keep the old value for the whole operation. They change only at the SIGN edge, an idle mthi/mtlo edge, or reset.

## Structure
- Shared package or header `muldiv_defs`:
  - op encodings `MD_MULT`/`MD_MULTU`/`MD_DIV`/`MD_DIVU`.
  - state encodings `MD_IDLE`/`MD_CALC`/`MD_SIGN`.
- Sub-module `muldiv_iter`: the per-cycle shift-add/restore datapath step, purely combinational.
- `muldiv_unit` owns the FSM, counter, operand/sign registers, HI/LO and stall logic.

## Test plan
- mult 0xFFFF_FFFF × 0x0000_0002 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFE after 33 cycles. multu with the same operands → HI = 0x0000_0001, LO = 0xFFFF_FFFE.
- div 0xFFFF_FFF9 (−7) ÷ 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. divu 7 ÷ 2 → LO = 3, HI = 1. div 0x8000_0000 ÷ 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0.
- div 5 ÷ 0 and divu 5 ÷ 0 → HI = 5, LO = 0xFFFF_FFFF, `busy` low after 33 cycles.
- mfhi held from cycle 1 of a mult → `stall` = 1 through E33, then 0. `rdata` equals the new HI in that cycle. A second `start` held during busy is accepted only after `busy` falls.
- Idle mthi + mtlo with `wdata` = 0x1234_5678 → both HI and LO = 0x1234_5678. mthi with `start` in the same idle cycle → mthi dropped, the operation result lands.
- `rst` at cycle 10 of a divide → next cycle `busy` = 0, `hi` = `lo` = 0. A following mult 3 × 4 → LO = 12, HI = 0.
